pacman_input_ctrl: RTL and testbench

//  Input front-end feeding the pacman core's I_JOYSTICK_A / I_SW pins. Decodes MiSTer ps2_key

---
 rtl/pacman_input_pkg.sv | 26 ++
 rtl/pacman_ps2_keys.sv | 59 +++++
 rtl/pacman_input_ctrl.sv | 139 +++++++++++++
 tb/tb_pacman_input_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pacman_input_pkg.sv
// Shared constants for the pacman input front-end: PS/2 set-2 scan codes,
// coin sequencer states and the MiSTer joystick bit layout.
package pacman_input_pkg;

   localparam logic [7:0] KEY_UP    = 8'h75;
   localparam logic [7:0] KEY_DOWN  = 8'h72;
   localparam logic [7:0] KEY_LEFT  = 8'h6B;
   localparam logic [7:0] KEY_RIGHT = 8'h74;
   localparam logic [7:0] KEY_SPACE = 8'h29;
   localparam logic [7:0] KEY_LCTRL = 8'h14;
   localparam logic [7:0] KEY_F1    = 8'h05;
   localparam logic [7:0] KEY_F2    = 8'h06;

   localparam logic [7:0] PFX_EXT   = 8'hE0;
   localparam logic [7:0] PFX_BREAK = 8'hF0;

   typedef enum logic [1:0] {IDLE, COIN, GAP, START} coin_state_t;

   localparam int BTN_RIGHT  = 0;
   localparam int BTN_LEFT   = 1;
   localparam int BTN_DOWN   = 2;
   localparam int BTN_UP     = 3;
   localparam int BTN_START1 = 4;
   localparam int BTN_START2 = 5;

endpackage

// File: rtl/pacman_ps2_keys.sv
// Decodes hps_io ps2_key toggle records into held key levels.
// One edge from a toggle to the updated key register; no backpressure.
module pacman_ps2_keys
   import pacman_input_pkg::*;
(
   input  logic        clk_sys,
   input  logic        reset,
   input  logic [64:0] ps2_key,
   output logic        ku,
   output logic        kd,
   output logic        kl,
   output logic        kr,
   output logic        kf,
   output logic        ks1,
   output logic        ks2
);

   logic       toggle_q;
   logic       key_event;
   logic       pressed;
   logic       extended;
   logic [7:0] code;

   always_comb begin
      key_event = (ps2_key[64] != toggle_q) && (ps2_key[63:24] == 40'd0);
      pressed   = (ps2_key[15:8] != PFX_BREAK);
      extended  = pressed ? (ps2_key[15:8] == PFX_EXT) : (ps2_key[23:16] == PFX_EXT);
      code      = ps2_key[7:0];
   end

   // Tracker reloads from the live toggle on reset so reset itself is never an event.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         toggle_q <= ps2_key[64];
         ku  <= 1'b0;
         kd  <= 1'b0;
         kl  <= 1'b0;
         kr  <= 1'b0;
         kf  <= 1'b0;
         ks1 <= 1'b0;
         ks2 <= 1'b0;
      end else begin
         toggle_q <= ps2_key[64];
         if (key_event) begin
            case (code)
               KEY_UP:    ku <= pressed;
               KEY_DOWN:  kd <= pressed;
               KEY_LEFT:  kl <= pressed;
               KEY_RIGHT: kr <= pressed;
               KEY_SPACE, KEY_LCTRL: if (!extended) kf <= pressed;
               KEY_F1:    if (!extended) ks1 <= pressed;
               KEY_F2:    if (!extended) ks2 <= pressed;
               default: ;
            endcase
         end
      end
   end

endmodule

// File: rtl/pacman_input_ctrl.sv
// Merges keyboard and joysticks into I_JOYSTICK_A / I_SW, with a timed coin->gap->start sequencer.
// joy_a_n: 1 edge from joystick, 2 from a key; sw/busy: registered state decode; extra start requests while busy are dropped.
module pacman_input_ctrl
   import pacman_input_pkg::*;
#(
   parameter int COIN_CYCLES  = 2400000,
   parameter int GAP_CYCLES   = 1200000,
   parameter int START_CYCLES = 2400000
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic [64:0] ps2_key,
   input  logic [15:0] joystick_0,
   input  logic [15:0] joystick_1,
   input  logic        rotate,
   output logic [4:0]  joy_a_n,
   output logic [3:0]  sw,
   output logic        busy
);

   localparam int MAX_CYCLES = (COIN_CYCLES > GAP_CYCLES)
                               ? ((COIN_CYCLES > START_CYCLES) ? COIN_CYCLES : START_CYCLES)
                               : ((GAP_CYCLES > START_CYCLES) ? GAP_CYCLES : START_CYCLES);
   localparam int CNT_W = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

   localparam logic [CNT_W-1:0] COIN_LOAD  = CNT_W'(COIN_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0] START_LOAD = CNT_W'(START_CYCLES - 1);

   logic ku, kd, kl, kr, kf, ks1, ks2;

   pacman_ps2_keys u_keys (
      .clk_sys (clk_sys),
      .reset   (reset),
      .ps2_key (ps2_key),
      .ku      (ku),
      .kd      (kd),
      .kl      (kl),
      .kr      (kr),
      .kf      (kf),
      .ks1     (ks1),
      .ks2     (ks2)
   );

   logic [5:0]       j;
   logic             c_up, c_dn, c_lf, c_rt;
   logic             up, dn, lf, rt;
   logic [4:0]       joy_nxt;
   logic             s1, s2, s1_q, s2_q, s1_edge, s2_edge;
   coin_state_t      state_q, state_nxt;
   logic [CNT_W-1:0] cnt_q, cnt_nxt;
   logic             sel_q, sel_nxt;
   logic [3:0]       sw_nxt;

   always_comb begin
      j    = joystick_0[5:0] | joystick_1[5:0];
      c_up = ku | j[BTN_UP];
      c_dn = kd | j[BTN_DOWN];
      c_lf = kl | j[BTN_LEFT];
      c_rt = kr | j[BTN_RIGHT];
      // Horz orientation turns the cabinet a quarter turn: left becomes up, up becomes right.
      if (rotate) begin
         up = c_lf;
         dn = c_rt;
         lf = c_dn;
         rt = c_up;
      end else begin
         up = c_up;
         dn = c_dn;
         lf = c_lf;
         rt = c_rt;
      end
      joy_nxt = ~{kf, rt, lf, dn, up};
      s1      = ks1 | j[BTN_START1];
      s2      = ks2 | j[BTN_START2];
      s1_edge = s1 & ~s1_q;
      s2_edge = s2 & ~s2_q;
   end

   always_comb begin
      state_nxt = state_q;
      cnt_nxt   = cnt_q;
      sel_nxt   = sel_q;
      case (state_q)
         IDLE: begin
            if (s1_edge || s2_edge) begin
               state_nxt = COIN;
               cnt_nxt   = COIN_LOAD;
               sel_nxt   = s1_edge;
            end
         end
         COIN: begin
            if (cnt_q == '0) begin
               state_nxt = GAP;
               cnt_nxt   = GAP_LOAD;
            end else begin
               cnt_nxt = cnt_q - 1'b1;
            end
         end
         GAP: begin
            if (cnt_q == '0) begin
               state_nxt = START;
               cnt_nxt   = START_LOAD;
            end else begin
               cnt_nxt = cnt_q - 1'b1;
            end
         end
         START: begin
            if (cnt_q == '0) state_nxt = IDLE;
            else             cnt_nxt   = cnt_q - 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
      sw_nxt = {(state_q == START) && !sel_q, state_q == COIN, 1'b0, (state_q == START) && sel_q};
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         sel_q   <= 1'b0;
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         joy_a_n <= 5'b11111;
         sw      <= 4'b0000;
         busy    <= 1'b0;
      end else begin
         state_q <= state_nxt;
         cnt_q   <= cnt_nxt;
         sel_q   <= sel_nxt;
         s1_q    <= s1;
         s2_q    <= s2;
         joy_a_n <= joy_nxt;
         sw      <= sw_nxt;
         busy    <= (state_q != IDLE);
      end
   end

endmodule

// File: tb/tb_pacman_input_ctrl.sv
// Self-checking bench for pacman_input_ctrl: directed tables, hand-written sequencer cases,
// and a randomized run against a cycle-level behavioural model.
module tb_pacman_input_ctrl;
   import pacman_input_pkg::*;

   localparam int COIN = 4;
   localparam int GAPC = 2;
   localparam int STRT = 3;
   localparam int SEQ_SPAN = COIN + GAPC + STRT + 1;

   logic        clk_sys = 1'b0;
   logic        reset;
   logic [64:0] ps2_key;
   logic [15:0] joystick_0, joystick_1;
   logic        rotate;
   logic [4:0]  joy_a_n;
   logic [3:0]  sw;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;

   pacman_input_ctrl #(.COIN_CYCLES(COIN), .GAP_CYCLES(GAPC), .START_CYCLES(STRT)) dut (
      .clk_sys    (clk_sys),
      .reset      (reset),
      .ps2_key    (ps2_key),
      .joystick_0 (joystick_0),
      .joystick_1 (joystick_1),
      .rotate     (rotate),
      .joy_a_n    (joy_a_n),
      .sw         (sw),
      .busy       (busy)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic key_evt(input bit press, input bit ext, input logic [7:0] code, input logic [39:0] upper);
      logic [7:0] b1, b2;
      b1 = press ? (ext ? 8'hE0 : 8'h00) : 8'hF0;
      b2 = (!press && ext) ? 8'hE0 : 8'h00;
      ps2_key = {~ps2_key[64], upper, b2, b1, code};
   endtask

   // {busy, sw} expected k edges after the edge that accepted a start request.
   function automatic logic [4:0] seq_exp(input int k, input bit sel);
      if (k >= 1 && k <= COIN)                   return 5'b1_0100;
      if (k > COIN && k <= COIN + GAPC)          return 5'b1_0000;
      if (k > COIN + GAPC && k <= COIN + GAPC + STRT) return sel ? 5'b1_0001 : 5'b1_1000;
      return 5'b0_0000;
   endfunction

   typedef struct {
      logic [15:0] j0;
      logic [15:0] j1;
      logic        rot;
      logic [4:0]  exp;
   } vec_t;

   vec_t vecs[10];

   // Behavioural model state: key levels 0 up,1 down,2 left,3 right,4 fire,5 start1,6 start2.
   bit  mk[7];
   bit  mtog, ms1p, ms2p, mact, msel;
   int  mstart, mn;

   task automatic model_reset();
      for (int i = 0; i < 7; i++) mk[i] = 1'b0;
      mtog = ps2_key[64];
      ms1p = 1'b0;
      ms2p = 1'b0;
      mact = 1'b0;
      msel = 1'b0;
      mstart = 0;
      mn = 0;
   endtask

   // Expected outputs after the coming edge, then fold this cycle's key event into the model.
   task automatic model_step(output logic [4:0] exp_joy, output logic [4:0] exp_seq);
      logic [5:0] jj;
      bit comb[4];
      int src[4];
      bit s1, s2, e1, e2, pr, ex;
      jj = joystick_0[5:0] | joystick_1[5:0];
      comb[0] = mk[0] | jj[3];
      comb[1] = mk[1] | jj[2];
      comb[2] = mk[2] | jj[1];
      comb[3] = mk[3] | jj[0];
      if (rotate) src = '{2, 3, 1, 0};
      else        src = '{0, 1, 2, 3};
      exp_joy = ~{mk[4], comb[src[3]], comb[src[2]], comb[src[1]], comb[src[0]]};
      s1 = mk[5] | jj[4];
      s2 = mk[6] | jj[5];
      e1 = s1 && !ms1p;
      e2 = s2 && !ms2p;
      ms1p = s1;
      ms2p = s2;
      if ((e1 || e2) && (!mact || (mn - mstart) >= SEQ_SPAN)) begin
         mact = 1'b1;
         mstart = mn;
         msel = e1;
      end
      exp_seq = mact ? seq_exp(mn - mstart, msel) : 5'b0;
      if (ps2_key[64] != mtog) begin
         if (ps2_key[63:24] == 40'd0) begin
            pr = (ps2_key[15:8] != 8'hF0);
            ex = pr ? (ps2_key[15:8] == 8'hE0) : (ps2_key[23:16] == 8'hE0);
            case (ps2_key[7:0])
               8'h75: mk[0] = pr;
               8'h72: mk[1] = pr;
               8'h6B: mk[2] = pr;
               8'h74: mk[3] = pr;
               8'h29, 8'h14: if (!ex) mk[4] = pr;
               8'h05: if (!ex) mk[5] = pr;
               8'h06: if (!ex) mk[6] = pr;
               default: ;
            endcase
         end
         mtog = ps2_key[64];
      end
      mn++;
   endtask

   initial begin
      logic [7:0]  codes[9];
      logic [4:0]  ej, es;
      logic [1:0]  st0;
      logic [39:0] up_bits;
      int busy_cnt, sw3_cnt;

      ps2_key    = {1'b1, 64'd0};
      joystick_0 = '0;
      joystick_1 = '0;
      rotate     = 1'b0;
      reset      = 1'b1;

      // Reset with toggle already high: no key event afterwards.
      step();
      step();
      check("reset_joy", joy_a_n, 5'b11111);
      check("reset_sw", sw, 4'b0000);
      check("reset_busy", busy, 1'b0);
      reset = 1'b0;
      step();
      step();
      step();
      check("post_reset_joy", joy_a_n, 5'b11111);
      check("post_reset_sw", {busy, sw}, 5'b0);

      // Keyboard press/release latency.
      key_evt(1, 0, KEY_UP, 40'd0);
      step();
      check("up_press_edge1", joy_a_n, 5'b11111);
      step();
      check("up_press_edge2", joy_a_n, 5'b11110);
      key_evt(0, 0, KEY_UP, 40'd0);
      step();
      check("up_release_edge1", joy_a_n, 5'b11110);
      step();
      check("up_release_edge2", joy_a_n, 5'b11111);
      key_evt(1, 1, KEY_UP, 40'd0);
      step();
      step();
      check("ext_up_press", joy_a_n, 5'b11110);
      key_evt(0, 1, KEY_UP, 40'd0);
      step();
      step();
      check("ext_up_release", joy_a_n, 5'b11111);
      key_evt(1, 0, KEY_SPACE, 40'd0);
      step();
      step();
      check("fire_press", joy_a_n, 5'b01111);
      key_evt(0, 0, KEY_SPACE, 40'd0);
      step();
      step();
      check("fire_release", joy_a_n, 5'b11111);
      key_evt(1, 1, KEY_SPACE, 40'd0);
      step();
      step();
      check("ext_space_no_fire", joy_a_n, 5'b11111);

      // Rotate remap from joystick_1, then an event with non-zero upper bits.
      rotate = 1'b1;
      joystick_1 = 16'h0008;
      step();
      check("rot_up_to_right", joy_a_n, 5'b10111);
      key_evt(1, 0, KEY_DOWN, 40'd1);
      step();
      step();
      check("upper_bits_ignored", joy_a_n, 5'b10111);
      joystick_1 = '0;
      rotate = 1'b0;
      step();
      check("rot_clear", joy_a_n, 5'b11111);

      // Direction merge table.
      vecs[0] = '{16'h0001, 16'h0000, 1'b0, 5'b10111};
      vecs[1] = '{16'h0002, 16'h0000, 1'b0, 5'b11011};
      vecs[2] = '{16'h0000, 16'h0004, 1'b0, 5'b11101};
      vecs[3] = '{16'h0000, 16'h0008, 1'b0, 5'b11110};
      vecs[4] = '{16'h0008, 16'h0000, 1'b1, 5'b10111};
      vecs[5] = '{16'h0002, 16'h0000, 1'b1, 5'b11110};
      vecs[6] = '{16'h0004, 16'h0000, 1'b1, 5'b11011};
      vecs[7] = '{16'h0001, 16'h0000, 1'b1, 5'b11101};
      vecs[8] = '{16'h0001, 16'h0002, 1'b0, 5'b10011};
      vecs[9] = '{16'hFFC0, 16'hFFC0, 1'b0, 5'b11111};
      for (int i = 0; i < 10; i++) begin
         joystick_0 = vecs[i].j0;
         joystick_1 = vecs[i].j1;
         rotate     = vecs[i].rot;
         step();
         check($sformatf("merge_vec%0d", i), joy_a_n, vecs[i].exp);
      end
      joystick_0 = '0;
      joystick_1 = '0;
      rotate = 1'b0;
      step();

      // Full start1 sequence from a joystick edge.
      busy_cnt = 0;
      sw3_cnt = 0;
      joystick_0 = 16'h0010;
      for (int k = 0; k <= 12; k++) begin
         step();
         check($sformatf("seq1_k%0d", k), {busy, sw}, seq_exp(k, 1'b1));
         if (busy) busy_cnt++;
         if (sw[3]) sw3_cnt++;
      end
      check("seq1_busy_cycles", busy_cnt, COIN + GAPC + STRT);
      check("seq1_sw3_never", sw3_cnt, 0);
      joystick_0 = '0;
      step();

      // Simultaneous edges pick start1; a second request during GAP is dropped.
      joystick_0 = 16'h0030;
      for (int k = 0; k <= 15; k++) begin
         step();
         check($sformatf("seq2_k%0d", k), {busy, sw}, seq_exp(k, 1'b1));
         if (k == 1) joystick_0 = '0;
         if (k == 4) joystick_0 = 16'h0030;
      end
      joystick_0 = '0;
      step();

      // Start2 via keyboard F2.
      key_evt(1, 0, KEY_F2, 40'd0);
      step();
      for (int k = 0; k <= 10; k++) begin
         step();
         check($sformatf("seq_f2_k%0d", k), {busy, sw}, seq_exp(k, 1'b0));
      end
      key_evt(0, 0, KEY_F2, 40'd0);
      step();
      step();

      // Reset during COIN.
      joystick_0 = 16'h0010;
      step();
      check("rst_seq_k0", {busy, sw}, seq_exp(0, 1'b1));
      joystick_0 = '0;
      step();
      check("rst_seq_k1", {busy, sw}, seq_exp(1, 1'b1));
      reset = 1'b1;
      step();
      check("rst_mid_coin", {busy, sw}, 5'b0);
      reset = 1'b0;
      for (int k = 0; k < 12; k++) begin
         step();
         check($sformatf("rst_idle_k%0d", k), {busy, sw}, 5'b0);
      end

      // Randomized run against the behavioural model.
      reset = 1'b1;
      step();
      reset = 1'b0;
      model_reset();
      codes = '{KEY_UP, KEY_DOWN, KEY_LEFT, KEY_RIGHT, KEY_SPACE, KEY_LCTRL, KEY_F1, KEY_F2, 8'h11};
      st0 = 2'b00;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(3) == 0) begin
            up_bits = ($urandom_range(7) == 0) ? (40'd1 << $urandom_range(39)) : 40'd0;
            key_evt(1'($urandom_range(1)), 1'($urandom_range(1)), codes[$urandom_range(8)], up_bits);
         end
         if ($urandom_range(19) == 0) st0[0] = ~st0[0];
         if ($urandom_range(19) == 0) st0[1] = ~st0[1];
         joystick_0 = (16'($urandom) & 16'hFFCF) | {10'd0, st0, 4'd0};
         joystick_1 = ($urandom_range(3) == 0) ? (16'($urandom) & 16'hFFCF) : 16'h0000;
         if ($urandom_range(31) == 0) rotate = ~rotate;
         model_step(ej, es);
         step();
         check("rand_joy", joy_a_n, ej);
         check("rand_sw", sw, es[3:0]);
         check("rand_busy", busy, es[4]);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
